// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the mux select arbiter.
// Requester count, owner index width, FSM states and a one-hot helper.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// The master side is the requester group; the slave side is the arbiter.
interface mux_sel_arbiter_if;
    import mux_arb_pkg::*;

    logic [N_REQ-1:0] iReq;
    logic             iDone;
    logic [N_REQ-1:0] oGnt;
    logic             oS1;
    logic             oS0;
    logic             oBusy;
    logic             oTimeout;

    modport master (
        output iReq, iDone,
        input  oGnt, oS1, oS0, oBusy, oTimeout
    );

    modport slave (
        input  iReq, iDone,
        output oGnt, oS1, oS0, oBusy, oTimeout
    );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request bit scanning
// start, start+1, ... modulo N_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        valid = 1'b0;
        idx   = start;
        cand  = start;
        for (int k = 0; k < N_REQ; k++) begin
            cand = start + IDX_W'(k);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared 4:1 mux selects; grants are held until
// done, request drop or hold limit, with zero-bubble handoff on release.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    mux_sel_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] next_start;
    logic             own_req;
    logic             hold_limit;
    logic             rel;
    logic             timeout_c;
    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] pick_req;
    logic [IDX_W-1:0] pick_start;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    assign next_start = owner_q + IDX_W'(1);
    assign own_req    = bus.iReq[owner_q];
    assign hold_limit = (cnt_q == CNT_LAST);
    assign rel        = bus.iDone || !own_req || hold_limit;
    // iDone wins over the hold limit, so a coincident done is a normal release.
    assign timeout_c  = hold_limit && !bus.iDone && own_req;
    assign masked_req = timeout_c ? (bus.iReq & ~onehot(owner_q)) : bus.iReq;

    // One picker serves both the IDLE grant and the same-cycle handoff.
    assign pick_req   = (state_q == IDLE) ? bus.iReq : masked_req;
    assign pick_start = (state_q == IDLE) ? ptr_q : next_start;

    rr_pick u_pick (
        .req   (pick_req),
        .start (pick_start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    cnt_d   = '0;
                end
            end

            GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (rel) begin
                    ptr_d     = next_start;
                    timeout_d = timeout_c;
                    if (pick_valid) begin
                        owner_d = pick_idx;
                        gnt_d   = onehot(pick_idx);
                        cnt_d   = '0;
                    end else begin
                        // owner_q is kept so the mux selects stay stable while idle.
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (iRst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.oGnt     = gnt_q;
    assign bus.oS1      = owner_q[1];
    assign bus.oS0      = owner_q[0];
    assign bus.oBusy    = |gnt_q;
    assign bus.oTimeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with HOLD_MAX=4; expected outputs are
// queued as each cycle is driven and popped after the following edge.
module tb_mux_sel_arbiter;
    import mux_arb_pkg::*;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    logic iClk;
    logic iRst;
    int   n_errors;
    int   n_checks;
    exp_t sb_q[$];

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(
        .HOLD_MAX (4),
        .CNT_W    (8)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input string field, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s %s: observed %b expected %b", tag, field, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
    task automatic cyc(input string tag, input logic rst, input logic [3:0] req, input logic done,
                       input logic [3:0] g, input logic [1:0] s, input logic t);
        exp_t e;
        iRst       = rst;
        bus.iReq   = req;
        bus.iDone  = done;
        sb_q.push_back('{gnt: g, sel: s, busy: (g != 4'b0000), to: t});
        @(posedge iClk);
        #1;
        e = sb_q.pop_front();
        check(tag, "gnt",  bus.oGnt,                   e.gnt);
        check(tag, "sel",  {2'b00, bus.oS1, bus.oS0},  {2'b00, e.sel});
        check(tag, "busy", {3'b000, bus.oBusy},        {3'b000, e.busy});
        check(tag, "tout", {3'b000, bus.oTimeout},     {3'b000, e.to});
    endtask

    initial begin
        n_errors  = 0;
        n_checks  = 0;
        iRst      = 1'b1;
        bus.iReq  = 4'b0000;
        bus.iDone = 1'b0;

        // Reset held with all requests active
        cyc("rst0", 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);
        cyc("rst1", 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);

        // Single request from requester 2, released by done together with request drop
        cyc("single_c1", 1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        cyc("single_c2", 1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        cyc("single_c3", 1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        cyc("single_rel", 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0);
        cyc("single_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);

        // Round-robin fairness from a fresh pointer
        cyc("rr_rst", 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);
        cyc("rr_g0", 1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc("rr_hold", 1'b0, 4'b1111, 1'b0, 4'(1 << (i - 1)), 2'(i - 1), 1'b0);
            cyc("rr_next", 1'b0, 4'b1111, 1'b1, 4'(1 << (i % 4)), 2'(i % 4), 1'b0);
        end

        // Timeout handoff between requesters 0 and 1
        cyc("to_rst", 1'b1, 4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc("to_own0", 1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0);
        cyc("to_hand1", 1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc("to_own1", 1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0);
        cyc("to_hand0", 1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1);

        // Sole requester timing out: one idle cycle, then re-granted
        cyc("sole_rst", 1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++)
                cyc("sole_own", 1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
            cyc("sole_gap", 1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b1);
        end

        // Move the pointer to 3, then reset mid-grant at cnt=2
        cyc("mid_g2", 1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        cyc("mid_rel", 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("mid_own2", 1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        cyc("mid_rst", 1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0);
        cyc("mid_ptr0", 1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0);

        // Done coincident with the hold limit: plain release, no pulse, no masking
        for (int i = 0; i < 3; i++)
            cyc("sim_own1", 1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0);
        cyc("sim_done1", 1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("sim_own3", 1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
        cyc("sim_nomask", 1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b0);

        // Owner drops its request: immediate handoff to the waiting requester
        cyc("drop_hand", 1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
        cyc("drop_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that shares the 4-input select multiplexer of the CPU datapath (a 4-way data source feeding one shared consumer) between four requesters. It owns the mux select pair, so exactly one requester drives the shared path at a time. Each grant is held until the owner finishes, drops its request, or exceeds a hold limit. The block sits beside the 4-to-1 mux: its oS1/oS0 drive the mux selects directly, and its oGnt returns acknowledge to the requesters.

## Interface
- HOLD_MAX, 16: maximum consecutive grant cycles per owner, range 2..256.
- CNT_W, 8: width of the hold counter, with 2^CNT_W >= HOLD_MAX.
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iReq  in  4  request per requester; bit i is requester i, which drives mux input i.
- iDone  in  1  current owner ends its transaction this cycle.
- oGnt  out  4  one-hot grant, registered; all zeros when idle.
- oS1  out  1  mux select MSB, equal to owner index bit 1; registered.
- oS0  out  1  mux select LSB, equal to owner index bit 0; registered.
- oBusy  out  1  high whenever oGnt is non-zero.
- oTimeout  out  1  one-cycle pulse; a grant was revoked by the hold limit.

## Operation
- States: IDLE and GRANT. Internal registers:
  - owner, 2 bits
  - ptr, 2 bits: round-robin start point
  - cnt, CNT_W bits
- Pick function (combinational): the first set bit of a 4-bit request vector, scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - If iReq != 0: winner = pick(iReq). Next cycle: state GRANT, owner = winner, oGnt = onehot(winner), {oS1,oS0} = winner, cnt = 0.
  - Otherwise: stay in IDLE.
- GRANT:
  - Each cycle, cnt increments.
  - Release condition: iDone=1, or iReq[owner]=0, or cnt == HOLD_MAX-1.
  - Timeout is the release condition cnt == HOLD_MAX-1 while iDone=0 and iReq[owner]=1.
  - On release, ptr is set to owner+1 (mod 4).
- Handoff on release, with zero bubble:
  - Arbitrate in the same cycle among the masked request vector.
  - Use pick with ptr replaced by owner+1.
  - The masked vector is iReq with bit owner cleared on timeout, and iReq unmasked otherwise.
  - If a winner exists: stay in GRANT with the new owner; cnt = 0.
  - If no winner exists: go to IDLE; oGnt = 0.
- {oS1,oS0} hold the last owner while in IDLE, so the mux output stays stable; they are not forced to 00.
- oTimeout is high for exactly the one cycle after a timeout release.
- Requests arriving mid-grant never pre-empt the owner. They wait for release or timeout.

## Timing
- Reset values:
  - state IDLE, owner 0, ptr 0, cnt 0
  - oGnt 0000, oS1 0, oS0 0, oBusy 0, oTimeout 0
- Reset dominates all other inputs in the same cycle, including mid-grant. The grant drops on the next edge.
- Grant latency: 1 cycle from iReq rising in IDLE to oGnt/oS valid.
- Release latency: the release condition is seen in cycle t; the new oGnt (or zeros) appears at t+1.
- oGnt, oS1/oS0 and oBusy all change on the same edge, with no glitch between select and grant.
- Grant duration bound: at most HOLD_MAX consecutive cycles for one owner.
- A sole requester that times out gets one IDLE cycle and is then re-granted.
- Simultaneous iDone and timeout: treat the release as iDone. No oTimeout pulse; no masking.
- A requester whose iReq drops before it is granted loses its turn without effect.

## Structure
- Package mux_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - N_REQ = 4
  - IDX_W = 2
  - the onehot-from-index helper function
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req[3:0], start[1:0].
  - Outputs: valid, idx[1:0].
  - Instantiated once and fed either iReq or the masked vector, so both the IDLE and handoff paths share it.

## Test plan
- Reset: hold iRst for 2 cycles with iReq=1111. Expect oGnt=0000, {oS1,oS0}=00, oBusy=0 and oTimeout=0 throughout.
- Single request:
  - Stimulus: iReq=0100 from cycle 0; iDone=1 in cycle 3.
  - Cycles 1–3: oGnt=0100, {oS1,oS0}=10, oBusy=1.
  - Cycle 4: oGnt=0000, while {oS1,oS0} stays 10.
- Round-robin fairness:
  - Stimulus: iReq=1111 held; iDone pulsed in the second cycle of each grant.
  - Expect grant order 0,1,2,3,0 with no idle cycle between grants.
- Timeout handoff:
  - Stimulus: HOLD_MAX=4, iReq=0011 held, iDone=0.
  - Expect oGnt=0001 for exactly 4 cycles.
  - Then oGnt=0010, with a single-cycle oTimeout pulse aligned to the first 0010 cycle.
- Sole-requester timeout:
  - Stimulus: HOLD_MAX=4, iReq=0001 held.
  - Expect a repeating sequence: 4 cycles of oGnt=0001, then 1 cycle of 0000 with oTimeout=1.
- Mid-grant reset and simultaneous release:
  - Stimulus: iRst asserted during a grant with cnt=2.
  - Expect all outputs at reset values on the next edge, and ptr back to 0: with iReq=1010 after reset, requester 1 wins first.
  - Stimulus: iDone coincident with cnt == HOLD_MAX-1.
  - Expect no oTimeout pulse.
